and_unit_arbiter: RTL
=====================

// Module: and_unit_arbiter
// PURPOSE
//  Shares one W-bit bitwise-AND datapath (c = a & b) between NUM_REQ requesters.
//  - Round-robin grant.
//  - valid/ready handshake on each request port and on the single response port.
//  - Registered result, tagged with the requester ID.
//  - Sits between requesting blocks and the shared AND unit; imports my_pkg::* for N.
// PARAMETERS
//  W        my_pkg::N (8)  operand/result width
//  NUM_REQ  4              number of requesters, >=2
//  IDW      $clog2(NUM_REQ) requester ID width (derived, not overridable)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NUM_REQ     request i valid
//  req_ready  out  NUM_REQ     request i accepted this cycle (one-hot or zero)
//  req_a      in   NUM_REQ*W   operand a, requester i at [i*W +: W]
//  req_b      in   NUM_REQ*W   operand b, requester i at [i*W +: W]
//  rsp_valid  out  1           result valid
//  rsp_ready  in   1           consumer accepts result
//  rsp_data   out  W           a & b of the granted request
//  rsp_id     out  IDW         index of the granted requester
//  busy       out  1           1 in RESP state
//  grant_cnt  out  NUM_REQ*16  (ARB_PERF_CNT_EN only) per-requester grant counts
// BEHAVIOUR
//  - Reset, applied at a clk edge with rst=1:
//    - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//    - Any in-flight result is discarded.
//  - FSM states:
//    - IDLE:
//      - If any req_valid: pick the first valid index at or after rr_ptr (wrapping mod NUM_REQ).
//      - req_ready[g]=1 combinationally in the same cycle.
//      - At the edge, register rsp_data=a_g&b_g, rsp_id=g, rsp_valid=1.
//      - rr_ptr=(g+1)%NUM_REQ; go to RESP.
//      - No valid requests: stay in IDLE, req_ready=0.
//    - RESP:
//      - req_ready=0; rsp_valid=1; rsp_data/rsp_id held stable.
//      - rsp_ready=1 -> go to IDLE with rsp_valid=0 next cycle.
//      - No back-to-back accept in the same cycle as the response handshake.
//  - Latency: result is visible 1 cycle after the accept.
//    - Throughput: 1 op per 2 cycles with rsp_ready held high.
//  - req_ready depends only on state, req_valid and rr_ptr, never on rsp_ready.
//  - Requesters hold req_valid/operands until req_ready.
//    - A dropped req_valid before grant is legal; the arbiter ignores it.
//  - Wrap-around: rr_ptr=NUM_REQ-1 with grant there -> rr_ptr=0.
//  - Single requester continuously valid is granted every IDLE visit (no starvation of self).
//  - Each requester waits at most NUM_REQ-1 other grants.
//  - rsp_ready while rsp_valid=0: ignored.
// CONFIGURATION
//  - ARB_PERF_CNT_EN defined:
//    - Adds grant_cnt port and NUM_REQ 16-bit counters.
//    - Counter i increments on each req_ready[i]; saturates at 16'hFFFF.
//    - Counters clear on rst.
//  - ARB_PERF_CNT_EN undefined: port and counters absent; all other behaviour identical.
// TESTING
//  1. rst 2 cycles -> req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//  2. Only req1 valid, a=8'hF0, b=8'h3C, rsp_ready=1:
//     - req_ready=4'b0010 one cycle.
//     - Next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=1.
//  3. All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one grant per 2 cycles.
//  4. rsp_ready=0 for 5 cycles in RESP:
//     - rsp_data/rsp_id stable.
//     - req_ready=0 throughout.
//     - Accept resumes after rsp_ready=1.
//  5. rst asserted in RESP with rsp_valid=1 -> next cycle rsp_valid=0, rr_ptr=0.
//     - All valid then grants req0 first.
//  6. ARB_PERF_CNT_EN: 3 grants to req2 -> grant_cnt[2*16+:16]=3, others 0.
//     - Preload near max -> holds at 16'hFFFF.

Source files
------------

// File: rtl/my_pkg.sv
// Shared constants for the arbitrated datapath blocks.
package my_pkg;
    // Default operand/result width of the shared AND unit.
    localparam int N = 8;
endpackage

// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter
// Round-robin arbiter that shares one W-bit bitwise-AND datapath between
// NUM_REQ requesters. Each request port and the single response port use a
// valid/ready handshake. The result is registered and tagged with the ID of
// the requester that was granted. The grant pointer moves one past the
// requester that was just granted, so no requester waits for more than
// NUM_REQ-1 grants to other requesters.
// Optional feature: define ARB_PERF_CNT_EN to add the grant_cnt port. This
// adds one saturating 16-bit grant counter per requester.
module and_unit_arbiter
    import my_pkg::*;
#(
    parameter  int W       = N,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*W-1:0]   req_a,
    input  logic [NUM_REQ*W-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]  grant_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0]            at_or_after_ptr;
    logic [NUM_REQ-1:0]            masked_valid;
    logic [NUM_REQ-1:0]            search_valid;
    logic [NUM_REQ-1:0]            gnt_oh;
    logic [IDW-1:0][NUM_REQ-1:0]   id_cols;
    logic [W-1:0][NUM_REQ-1:0]     res_cols;
    logic [IDW-1:0]                grant_idx;
    logic [W-1:0]                  grant_res;

    // Requesters at or above the pointer take priority. If none of them is
    // valid, the search wraps around to the lowest-index valid requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ptr_mask
        assign at_or_after_ptr[gi] = (IDW'(gi) >= rr_ptr_q);
    end

    assign masked_valid = req_valid & at_or_after_ptr;
    assign search_valid = (|masked_valid) ? masked_valid : req_valid;
    // Isolate the lowest set bit to get a one-hot grant (zero if nothing is valid).
    assign gnt_oh       = search_valid & (~search_valid + NUM_REQ'(1));

    // Encode the grant and mux the AND result with AND-OR trees.
    // A one-hot select lets each output bit be a plain OR reduction.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        for (genvar bi = 0; bi < IDW; bi++) begin : g_id_bit
            localparam bit ID_BIT = ((gi >> bi) & 1) != 0;
            assign id_cols[bi][gi] = gnt_oh[gi] & ID_BIT;
        end
        for (genvar wi = 0; wi < W; wi++) begin : g_res_bit
            assign res_cols[wi][gi] = gnt_oh[gi] & req_a[gi*W + wi] & req_b[gi*W + wi];
        end
    end

    for (genvar bi = 0; bi < IDW; bi++) begin : g_id_reduce
        assign grant_idx[bi] = |id_cols[bi];
    end

    for (genvar wi = 0; wi < W; wi++) begin : g_res_reduce
        assign grant_res[wi] = |res_cols[wi];
    end

    // Next-state logic, request acceptance and response capture.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt_oh;
                if (|req_valid) begin
                    state_d    = RESP;
                    rsp_data_d = grant_res;
                    rsp_id_d   = grant_idx;
                    rr_ptr_d   = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and response registers. Reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef ARB_PERF_CNT_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        logic [15:0] cnt_q, cnt_d;

        // Count each accept for this requester, holding at the maximum value.
        always_comb begin
            cnt_d = cnt_q;
            if (req_ready[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Counter register, cleared on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt[gi*16 +: 16] = cnt_q;
    end
`endif

endmodule
